wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters:
  - the main pipeline's MEM/WB writeback;
  - a long-latency secondary unit (multi-cycle divider/multiplier).
- The pipeline has priority. Secondary results queue in a small buffer and drain into idle writeback slots.
- A starvation counter forces a one-cycle pipeline stall so that buffered results always retire.
- Exports a pending-destination mask so ID-stage hazard logic can stall RAW dependencies on queued results.

---
 rtl/wb_arb_pkg.sv | 15 +
 rtl/wb_pend_fifo.sv | 70 +++++++
 rtl/wb_port_arbiter.sv | 107 ++++++++++
 tb/tb_wb_port_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback-port arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default register address / data widths
//   wb_entry_t              : one buffered secondary result {rd, data}
//   gnt_src_t               : which requester owns the write port this cycle
package wb_arb_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_PIPE, GNT_SEC} gnt_src_t;
endpackage

// File: rtl/wb_pend_fifo.sv
// Circular buffer of pending secondary results.
//   clk, reset         : clock, async active-high reset
//   push/push_rd/_data : enqueue at wr_ptr (caller guarantees not full)
//   pop                : dequeue head (caller guarantees not empty)
//   count              : occupancy 0..DEPTH
//   head_rd/head_data  : oldest entry
//   ent_valid/ent_rd   : per-slot occupancy and destination, for the hazard mask
module wb_pend_fifo import wb_arb_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [ADDR_W-1:0]             push_rd,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [CNT_W-1:0]              count,
  output logic [ADDR_W-1:0]             head_rd,
  output logic [DATA_W-1:0]             head_data,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_rd
);
  logic [PTR_W-1:0]             rd_ptr, wr_ptr;
  logic [DEPTH-1:0]             vld;
  logic [DEPTH-1:0][ADDR_W-1:0] rd_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      // push and pop can only hit the same slot when the buffer is empty or
      // full, and the caller never issues the illegal half in those states.
      for (int i = 0; i < DEPTH; i++)
        vld[i] <= (vld[i] & ~(pop && rd_ptr == PTR_W'(i))) | (push && wr_ptr == PTR_W'(i));
    end
  end

  // Payload needs no reset: validity is tracked by vld.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr]   <= push_rd;
      data_q[wr_ptr] <= push_data;
    end
  end

  assign head_rd   = rd_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign ent_valid = vld;
  assign ent_rd    = rd_q;
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the MEM/WB
// pipeline (priority) and a buffered long-latency secondary unit.
//   clk, reset                   : clock, async active-high reset
//   pipe_reg_write/pipe_rd/_data : MEM/WB write request
//   sec_valid/sec_rd/sec_data    : secondary result; sec_ready = buffer not full
//   rf_we/rf_waddr/rf_wdata      : register-file write port
//   pipe_stall                   : forced stall so a starved buffer head retires
//   pend_mask                    : destinations of all buffered results
//   order_err                    : sticky, pipeline wrote a register still pending
module wb_port_arbiter import wb_arb_pkg::*; #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_reg_write,
  input  logic [ADDR_W-1:0]    pipe_rd,
  input  logic [DATA_W-1:0]    pipe_data,
  input  logic                 sec_valid,
  input  logic [ADDR_W-1:0]    sec_rd,
  input  logic [DATA_W-1:0]    sec_data,
  output logic                 sec_ready,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 pipe_stall,
  output logic [2**ADDR_W-1:0] pend_mask,
  output logic                 order_err
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SW    = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0]             count;
  logic [ADDR_W-1:0]            head_rd;
  logic [DATA_W-1:0]            head_data;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_rd;
  logic [SW-1:0]                starve_cnt;
  logic                         force_w, pipe_wr, push, pop;
  gnt_src_t                     gnt;

  // Registered state only: no same-cycle bypass through a dequeue.
  assign sec_ready = !reset && (count < CNT_W'(DEPTH));
  // x0 results are consumed but never stored.
  assign push      = sec_valid && sec_ready && (sec_rd != '0);
  assign pop       = (gnt == GNT_SEC);
  assign pipe_wr   = pipe_reg_write && (pipe_rd != '0);
  assign force_w   = (count != '0) && (starve_cnt == SW'(MAX_WAIT));
  assign pipe_stall = force_w;

  wb_pend_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_rd   (sec_rd),
    .push_data (sec_data),
    .pop       (pop),
    .count     (count),
    .head_rd   (head_rd),
    .head_data (head_data),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  // Grant: forced head, then pipeline, then head in an idle slot.
  // Reset gating keeps the write port quiet while reset is held.
  always_comb begin
    gnt = GNT_NONE;
    if (reset)               gnt = GNT_NONE;
    else if (force_w)        gnt = GNT_SEC;
    else if (pipe_wr)        gnt = GNT_PIPE;
    else if (count != '0)    gnt = GNT_SEC;
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (gnt)
      GNT_PIPE: begin rf_we = 1'b1; rf_waddr = pipe_rd; rf_wdata = pipe_data; end
      GNT_SEC:  begin rf_we = 1'b1; rf_waddr = head_rd; rf_wdata = head_data; end
      default:  ;
    endcase
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_valid[i]) pend_mask[ent_rd[i]] = 1'b1;
    pend_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      order_err  <= 1'b0;
    end else begin
      if (count == '0 || pop)             starve_cnt <= '0;
      else if (starve_cnt != SW'(MAX_WAIT)) starve_cnt <= starve_cnt + SW'(1);
      // Pipeline writing a register with an older result still queued means
      // the ID-stage interlock missed a hazard.
      if (pipe_wr && pend_mask[pipe_rd] && !force_w) order_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;
  localparam int DEPTH = 4, MAX_WAIT = 8, DATA_W = 32, ADDR_W = 5;

  logic clk = 1'b0, reset = 1'b1;
  logic pipe_reg_write = 0, sec_valid = 0;
  logic [ADDR_W-1:0] pipe_rd = '0, sec_rd = '0;
  logic [DATA_W-1:0] pipe_data = '0, sec_data = '0;
  logic sec_ready, rf_we, pipe_stall, order_err;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [31:0] pend_mask;

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .pipe_reg_write(pipe_reg_write), .pipe_rd(pipe_rd),
    .pipe_data(pipe_data), .sec_valid(sec_valid), .sec_rd(sec_rd), .sec_data(sec_data),
    .sec_ready(sec_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall), .pend_mask(pend_mask), .order_err(order_err));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of pending results, how long the head has been
  // passed over, and the sticky hazard flag.
  wb_entry_t q[$];
  int  waited = 0;
  bit  m_err = 0;
  bit  e_force;
  int  e_src;          // 0 none, 1 pipeline, 2 buffer head
  logic [31:0] e_mask;

  task automatic model_clear();
    q.delete(); waited = 0; m_err = 0;
  endtask

  task automatic cyc_check();
    logic e_we; logic [ADDR_W-1:0] e_a; logic [DATA_W-1:0] e_d;
    bit pw;
    @(negedge clk);
    e_mask = '0;
    foreach (q[i]) if (q[i].rd != 0) e_mask[q[i].rd] = 1'b1;
    e_force = (q.size() > 0) && (waited == MAX_WAIT);
    pw = pipe_reg_write && (pipe_rd != 0);
    if (e_force)            e_src = 2;
    else if (pw)            e_src = 1;
    else if (q.size() > 0)  e_src = 2;
    else                    e_src = 0;
    e_we = (e_src != 0); e_a = '0; e_d = '0;
    if (e_src == 1) begin e_a = pipe_rd; e_d = pipe_data; end
    if (e_src == 2) begin e_a = q[0].rd; e_d = q[0].data; end
    chk("rf_we", rf_we, e_we);
    chk("rf_waddr", rf_waddr, e_a);
    chk("rf_wdata", rf_wdata, e_d);
    chk("pipe_stall", pipe_stall, e_force);
    chk("sec_ready", sec_ready, q.size() < DEPTH);
    chk("pend_mask", pend_mask, e_mask);
    chk("order_err", order_err, m_err);
  endtask

  task automatic cyc_adv();
    int pre;
    @(posedge clk);
    pre = q.size();
    if (pipe_reg_write && pipe_rd != 0 && e_mask[pipe_rd] && !e_force) m_err = 1;
    if (e_src == 2) void'(q.pop_front());
    if (pre == 0 || e_src == 2) waited = 0;
    else if (waited < MAX_WAIT) waited++;
    if (sec_valid && pre < DEPTH && sec_rd != 0) q.push_back('{rd: sec_rd, data: sec_data});
    #1;
  endtask

  task automatic step(); cyc_check(); cyc_adv(); endtask

  task automatic do_reset_check(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_we"}, rf_we, 0);
    chk({tag, "_stall"}, pipe_stall, 0);
    chk({tag, "_ready"}, sec_ready, 0);
    chk({tag, "_mask"}, pend_mask, 0);
    chk({tag, "_waddr"}, rf_waddr, 0);
    chk({tag, "_wdata"}, rf_wdata, 0);
    chk({tag, "_err"}, order_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    int denied, nw;
    logic [ADDR_W-1:0] got_seq[5];
    bit seen;

    // Reset state with active-looking inputs.
    pipe_reg_write = 1; pipe_rd = 5; pipe_data = 32'hdead; sec_valid = 1; sec_rd = 6;
    #2;
    do_reset_check("rst0");
    pipe_reg_write = 0; sec_valid = 0;

    // 1: idle pipeline, result written the following cycle.
    sec_valid = 1; sec_rd = 7; sec_data = 32'h1234;
    cyc_check(); chk("t1_pend0", pend_mask[7], 0); cyc_adv();
    sec_valid = 0;
    cyc_check();
    chk("t1_we", rf_we, 1); chk("t1_waddr", rf_waddr, 7);
    chk("t1_wdata", rf_wdata, 32'h1234); chk("t1_pend1", pend_mask[7], 1);
    cyc_adv();
    cyc_check(); chk("t1_pend2", pend_mask[7], 0); cyc_adv();

    // 2: starvation then forced stall.
    pipe_reg_write = 1; pipe_rd = 3; pipe_data = 32'haaaa;
    sec_valid = 1; sec_rd = 9; sec_data = 32'h99;
    step();
    sec_valid = 0;
    denied = 0; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cyc_check();
      if (pipe_stall) begin
        seen = 1;
        chk("t2_force_waddr", rf_waddr, 9);
      end else denied++;
      cyc_adv();
    end
    chk("t2_stall_seen", seen, 1);
    chk("t2_denied", denied, MAX_WAIT);
    cyc_check();
    chk("t2_after_waddr", rf_waddr, 3); chk("t2_after_wdata", rf_wdata, 32'haaaa);
    chk("t2_after_stall", pipe_stall, 0);
    cyc_adv();

    // 3: fill to DEPTH under a busy pipeline, then drain in order.
    sec_valid = 1; sec_rd = 1;
    for (int c = 0; c < 6; c++) begin
      cyc_check();
      if (c == 4) chk("t3_full", sec_ready, 0);
      if (sec_ready && sec_rd < 5) begin cyc_adv(); sec_rd = sec_rd + 1; sec_data = {27'd0, sec_rd}; end
      else cyc_adv();
    end
    pipe_reg_write = 0;
    nw = 0;
    for (int c = 0; c < 12 && nw < 5; c++) begin
      cyc_check();
      if (rf_we) begin got_seq[nw] = rf_waddr; nw++; end
      if (sec_valid && sec_ready) begin cyc_adv(); sec_valid = 0; end
      else cyc_adv();
    end
    chk("t3_nw", nw, 5);
    for (int i = 0; i < 5; i++) chk("t3_order", got_seq[i], i + 1);

    // 4: x0 result is consumed and dropped.
    sec_valid = 1; sec_rd = 0; sec_data = 32'h55;
    step();
    sec_valid = 0;
    cyc_check(); chk("t4_we", rf_we, 0); chk("t4_mask", pend_mask, 0); cyc_adv();

    // 5: pipeline writes a pending register -> sticky order_err.
    pipe_reg_write = 1; pipe_rd = 3; pipe_data = 32'h1;
    sec_valid = 1; sec_rd = 12; sec_data = 32'hc;
    step();
    sec_valid = 0; pipe_rd = 12;
    step();
    pipe_rd = 3;
    cyc_check(); chk("t5_err", order_err, 1); cyc_adv();
    step(); step();
    cyc_check(); chk("t5_err_sticky", order_err, 1); cyc_adv();

    // 6: reset with a partly full buffer.
    sec_valid = 1; sec_rd = 20;
    step(); sec_rd = 21; step();
    sec_valid = 0;
    cyc_check(); chk("t6_pre_mask", pend_mask[21:20], 2'b11); cyc_adv();
    do_reset_check("t6_rst");
    pipe_reg_write = 0;
    cyc_check(); chk("t6_ready", sec_ready, 1); chk("t6_we", rf_we, 0); cyc_adv();

    // Randomized traffic against the model, with a mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset_check("rand_rst");
      cyc_check();
      cyc_adv();
      // A stalled MEM/WB re-presents the same write.
      if (!e_force) begin
        pipe_reg_write = ($urandom_range(0, 9) < 6);
        pipe_rd = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
        pipe_data = $urandom;
      end
      sec_valid = ($urandom_range(0, 9) < 4);
      sec_rd = ($urandom_range(0, 9) == 0) ? '0 : ADDR_W'($urandom);
      sec_data = $urandom;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
